// File: rtl/gpio_timer_pkg.sv
// Shared definitions for the GPIO/timer peripheral.
// Contents:
//   DEFAULT_BASE_ADDR : default byte address of the 64-byte register block
//   reg_idx_e         : register index (address[5:3]); byte offset = index * 8
//   CTRL_EN/CTRL_AR   : bit positions inside CTRL
//   STATUS_EXP        : bit position of the sticky expiry flag inside STATUS
package gpio_timer_pkg;

  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_0001_0000;

  // Register indices; the byte offsets are 0x00, 0x08, ... 0x38.
  typedef enum logic [2:0] {
    OFF_CTRL     = 3'd0,
    OFF_PRESCALE = 3'd1,
    OFF_RELOAD   = 3'd2,
    OFF_COUNT    = 3'd3,
    OFF_STATUS   = 3'd4,
    OFF_GPIO_OUT = 3'd5,
    OFF_GPIO_IN  = 3'd6,
    OFF_RESERVED = 3'd7
  } reg_idx_e;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AR    = 1;
  localparam int STATUS_EXP = 0;

endpackage

// File: rtl/gpio_timer_periph_if.sv
// Processor data-bus control signals seen by the peripheral.
// Signals:
//   address : byte address (64 bits)
//   read    : level read strobe
//   write   : level write strobe
// The bidirectional data lines are a plain inout port of the peripheral so
// that the tri-state net is resolved at one place in the hierarchy.
// Modports: master (processor side) drives, slave (peripheral side) samples.
interface gpio_timer_periph_if;
  logic [63:0] address;
  logic        read;
  logic        write;

  modport master (output address, output read, output write);
  modport slave  (input address, input read, input write);
endinterface

// File: rtl/gpio_timer_periph_prescaler.sv
// Prescaler for the peripheral down-counter.
// Ports:
//   clock    : system clock
//   reset    : asynchronous, active-high
//   en       : timer enable; while low the prescaler is held at 0
//   restart  : forces the prescaler back to 0 (EN rising by a CTRL write)
//   prescale : terminal value; tick period is prescale+1 clocks
//   tick     : combinational, high in the cycle the prescaler hits prescale
module timer_prescaler #(
  parameter int PRE_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             restart,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] pre;

  assign tick = en && !restart && (pre == prescale);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (!en || restart) begin
      pre <= '0;
    end else if (pre == prescale) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/gpio_timer_periph.sv
// Memory-mapped timer / GPIO peripheral.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   bus          : address/read/write from the processor (slave modport)
//   data         : bidirectional data; driven only while read && hit
//   gpio_in      : asynchronous switch inputs, two-flop synchronized
//   gpio_out     : LED register
//   irq          : mirror of STATUS.EXP
// Bus protocol: reads are combinational (same-cycle data while read && hit);
// writes are taken on the rising clock when write && hit && !read, so a
// simultaneous read suppresses the write.
module gpio_timer_periph
  import gpio_timer_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          GPIO_W    = 16,
  parameter int          CNT_W     = 32,
  parameter int          PRE_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  gpio_timer_periph_if.slave  bus,
  inout  wire  [63:0]         data,
  input  logic [GPIO_W-1:0]   gpio_in,
  output logic [GPIO_W-1:0]   gpio_out,
  output logic                irq
);

  logic              hit;
  reg_idx_e          idx;
  logic              wr_en;
  logic              tick;
  logic              expire;
  logic              restart;
  logic [63:0]       rdata;

  logic              ctrl_en;
  logic              ctrl_ar;
  logic [PRE_W-1:0]  prescale;
  logic [CNT_W-1:0]  reload;
  logic [CNT_W-1:0]  count;
  logic              exp_flag;
  logic [GPIO_W-1:0] sync1;
  logic [GPIO_W-1:0] sync2;

  // Byte lane bits of the address and the data bits above the widest
  // register carry no information for this block.
  logic unused_bits;
  assign unused_bits = ^{bus.address[2:0], data[63:CNT_W]};

  assign hit   = (bus.address[63:6] == BASE_ADDR[63:6]);
  assign idx   = reg_idx_e'(bus.address[5:3]);
  assign wr_en = bus.write && hit && !bus.read;

  // Only a CTRL write that turns EN on from off restarts the prescaler.
  assign restart = wr_en && (idx == OFF_CTRL) && data[CTRL_EN] && !ctrl_en;
  assign expire  = tick && (count == '0);
  assign irq     = exp_flag;

  timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clock    (clock),
    .reset    (reset),
    .en       (ctrl_en),
    .restart  (restart),
    .prescale (prescale),
    .tick     (tick)
  );

  // Hardware updates come first; bus writes later in the block override
  // them (RELOAD write beats a decrement, CTRL write beats the one-shot
  // EN clear). STATUS clear is gated so a same-cycle expiry still sets.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_en  <= 1'b0;
      ctrl_ar  <= 1'b0;
      prescale <= '0;
      reload   <= '0;
      count    <= '0;
      exp_flag <= 1'b0;
      gpio_out <= '0;
      sync1    <= '0;
      sync2    <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;

      if (tick) begin
        if (count != '0) begin
          count <= count - CNT_W'(1);
        end else begin
          exp_flag <= 1'b1;
          if (ctrl_ar) begin
            count <= reload;
          end else begin
            ctrl_en <= 1'b0;
          end
        end
      end

      if (wr_en) begin
        case (idx)
          OFF_CTRL: begin
            ctrl_en <= data[CTRL_EN];
            ctrl_ar <= data[CTRL_AR];
          end
          OFF_PRESCALE: prescale <= data[PRE_W-1:0];
          OFF_RELOAD: begin
            reload <= data[CNT_W-1:0];
            count  <= data[CNT_W-1:0];
          end
          OFF_STATUS: begin
            if (data[STATUS_EXP] && !expire) begin
              exp_flag <= 1'b0;
            end
          end
          OFF_GPIO_OUT: gpio_out <= data[GPIO_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      OFF_CTRL: begin
        rdata[CTRL_EN] = ctrl_en;
        rdata[CTRL_AR] = ctrl_ar;
      end
      OFF_PRESCALE: rdata = 64'(prescale);
      OFF_RELOAD:   rdata = 64'(reload);
      OFF_COUNT:    rdata = 64'(count);
      OFF_STATUS:   rdata[STATUS_EXP] = exp_flag;
      OFF_GPIO_OUT: rdata = 64'(gpio_out);
      OFF_GPIO_IN:  rdata = 64'(sync2);
      default:      rdata = '0;
    endcase
  end

  assign data = (bus.read && hit) ? rdata : 64'bz;

endmodule

// File: tb/tb_gpio_timer_periph.sv
// Directed bench for gpio_timer_periph. Inputs change just after the falling
// edge; outputs are sampled 1 time unit later, well before the rising edge.
// The data bus has a pull-up, so an undriven bus reads as all ones.
module tb_gpio_timer_periph;

  localparam logic [63:0] BASE       = 64'h0000_0000_0001_0000;
  localparam logic [63:0] A_CTRL     = BASE + 64'h00;
  localparam logic [63:0] A_PRESCALE = BASE + 64'h08;
  localparam logic [63:0] A_RELOAD   = BASE + 64'h10;
  localparam logic [63:0] A_COUNT    = BASE + 64'h18;
  localparam logic [63:0] A_STATUS   = BASE + 64'h20;
  localparam logic [63:0] A_GPIO_OUT = BASE + 64'h28;
  localparam logic [63:0] A_GPIO_IN  = BASE + 64'h30;
  localparam logic [63:0] A_RSV      = BASE + 64'h38;
  localparam logic [63:0] FLOAT      = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clock;
  logic        reset;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        irq;
  logic        drv_en;
  logic [63:0] drv_val;
  wire  [63:0] data;

  logic [63:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  gpio_timer_periph_if bus ();

  pullup pu_data (data);
  assign data = drv_en ? drv_val : 64'bz;

  gpio_timer_periph dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .data     (data),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard compare: pops the oldest expected value.
  task automatic compare(input string tag, input logic [63:0] got);
    logic [63:0] e;
    e = exp_q.pop_front();
    n_cmp++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, e);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    exp_q.push_back(expv);
    compare(tag, got);
  endtask

  // Driver tasks
  task automatic idle();
    bus.read  = 1'b0;
    bus.write = 1'b0;
    drv_en    = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] v);
    bus.address = a;
    bus.read    = 1'b0;
    bus.write   = 1'b1;
    drv_val     = v;
    drv_en      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    idle();
  endtask

  // read and write strobes together across a rising edge, bench driving data
  task automatic rw_drive(input logic [63:0] a, input logic [63:0] v);
    bus.address = a;
    bus.read    = 1'b1;
    bus.write   = 1'b1;
    drv_val     = v;
    drv_en      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    idle();
  endtask

  task automatic rd(input string tag, input logic [63:0] a, input logic [63:0] expv,
                    input logic with_write = 1'b0);
    exp_q.push_back(expv);
    bus.address = a;
    bus.read    = 1'b1;
    bus.write   = with_write;
    #1;
    compare(tag, data);
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    gpio_in     = '0;
    drv_val     = '0;
    bus.address = '0;
    idle();
    cyc(2);
    reset = 1'b0;
    cyc(1);

    // Reset values and idle bus
    for (int i = 0; i < 8; i++)
      rd($sformatf("rst_reg%0d", i), BASE + 64'(i * 8), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_gpio_out", 64'(gpio_out), 64'h0);
    cyc(1);

    // GPIO out, upper bits ignored
    wr(A_GPIO_OUT, 64'hFFFF_0000_0000_A5A5);
    chk("gpio_out_pin", 64'(gpio_out), 64'hA5A5);
    rd("gpio_out_rd", A_GPIO_OUT, 64'hA5A5);
    cyc(1);

    // GPIO in through the synchronizer
    gpio_in = 16'h0F0F;
    rd("gpio_in_c0", A_GPIO_IN, 64'h0);
    cyc(1);
    rd("gpio_in_c1", A_GPIO_IN, 64'h0);
    cyc(1);
    rd("gpio_in_c2", A_GPIO_IN, 64'h0F0F);

    // Non-hit reads leave the bus undriven
    rd("nohit_above", BASE + 64'h40, FLOAT);
    rd("nohit_zero", 64'h0, FLOAT);
    cyc(1);

    // One-shot, PRESCALE=0, RELOAD=3
    wr(A_PRESCALE, 64'h0);
    wr(A_RELOAD, 64'h3);
    wr(A_CTRL, 64'h1);
    for (int i = 0; i < 4; i++) begin
      rd($sformatf("oneshot_count%0d", i), A_COUNT, 64'(3 - i));
      if (i < 3) cyc(1);
    end
    chk("oneshot_irq_before", 64'(irq), 64'h0);
    cyc(1);
    chk("oneshot_irq", 64'(irq), 64'h1);
    rd("oneshot_status", A_STATUS, 64'h1);
    rd("oneshot_count_hold", A_COUNT, 64'h0);
    rd("oneshot_en_cleared", A_CTRL, 64'h0);
    cyc(3);
    rd("oneshot_count_hold2", A_COUNT, 64'h0);
    wr(A_STATUS, 64'h0);
    chk("w0_keeps_irq", 64'(irq), 64'h1);
    wr(A_STATUS, 64'h1);
    chk("w1c_irq", 64'(irq), 64'h0);

    // Auto-reload with PRESCALE=4, RELOAD=2: expiry every 15 clocks
    wr(A_PRESCALE, 64'h4);
    wr(A_RELOAD, 64'h2);
    wr(A_CTRL, 64'h3);
    cyc(14);
    chk("ar_irq_c14", 64'(irq), 64'h0);
    rd("ar_count_c14", A_COUNT, 64'h0);
    cyc(1);
    chk("ar_irq_c15", 64'(irq), 64'h1);
    rd("ar_reload", A_COUNT, 64'h2);
    wr(A_STATUS, 64'h1);
    chk("ar_w1c", 64'(irq), 64'h0);
    cyc(13);
    chk("ar_irq_c29", 64'(irq), 64'h0);
    wr(A_STATUS, 64'h1);
    chk("ar_w1c_vs_expiry", 64'(irq), 64'h1);
    rd("ar_reload2", A_COUNT, 64'h2);
    wr(A_CTRL, 64'h0);
    wr(A_STATUS, 64'h1);

    // RELOAD write on a tick edge
    wr(A_RELOAD, 64'd10);
    wr(A_CTRL, 64'h1);
    cyc(4);
    rd("col_pre", A_COUNT, 64'd10);
    wr(A_RELOAD, 64'd100);
    rd("col_reload_wins", A_COUNT, 64'd100);
    cyc(4);
    rd("col_hold", A_COUNT, 64'd100);
    cyc(1);
    rd("col_next_tick", A_COUNT, 64'd99);
    wr(A_CTRL, 64'h0);

    // CTRL write against the one-shot EN clear
    wr(A_PRESCALE, 64'h0);
    wr(A_RELOAD, 64'h0);
    wr(A_CTRL, 64'h1);
    wr(A_CTRL, 64'h1);
    rd("ctrl_write_wins", A_CTRL, 64'h1);
    chk("ctrl_col_irq", 64'(irq), 64'h1);
    cyc(1);
    rd("ctrl_hw_clear", A_CTRL, 64'h0);
    wr(A_STATUS, 64'h1);

    // read && write together
    rw_drive(A_GPIO_OUT, 64'h1234);
    chk("rw_no_update", 64'(gpio_out), 64'hA5A5);
    rd("rw_read_wins", A_GPIO_OUT, 64'hA5A5, 1'b1);
    cyc(1);

    // Read-only / reserved offsets, upper bits
    wr(A_RELOAD, 64'hDEAD_BEEF_0000_0007);
    rd("reload_upper0", A_RELOAD, 64'h7);
    rd("count_loaded", A_COUNT, 64'h7);
    cyc(1);
    wr(A_COUNT, 64'h55);
    rd("count_ro", A_COUNT, 64'h7);
    cyc(1);
    wr(A_GPIO_IN, 64'hFFFF);
    rd("gpio_in_ro", A_GPIO_IN, 64'h0F0F);
    cyc(1);
    wr(A_RSV, FLOAT);
    rd("rsv_reads0", A_RSV, 64'h0);
    rd("rsv_ctrl", A_CTRL, 64'h0);
    rd("rsv_prescale", A_PRESCALE, 64'h0);
    rd("rsv_status", A_STATUS, 64'h0);
    chk("rsv_gpio_out", 64'(gpio_out), 64'hA5A5);
    cyc(1);
    wr(BASE + 64'h2D, 64'h3C3C);
    chk("lowbits_ignored", 64'(gpio_out), 64'h3C3C);
    rd("lowbits_rd", BASE + 64'h2F, 64'h3C3C);
    cyc(1);

    // Asynchronous reset in the middle of operation
    wr(A_PRESCALE, 64'h0);
    wr(A_RELOAD, 64'h1);
    wr(A_CTRL, 64'h3);
    cyc(2);
    chk("pre_reset_irq", 64'(irq), 64'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_irq", 64'(irq), 64'h0);
    chk("async_gpio_out", 64'(gpio_out), 64'h0);
    for (int i = 0; i < 8; i++)
      rd($sformatf("async_reg%0d", i), BASE + 64'(i * 8), 64'h0);
    rd("async_nohit", BASE + 64'h80, FLOAT);
    bus.address = A_CTRL;
    #1;
    chk("no_read_float", data, FLOAT);
    @(negedge clock);
    reset = 1'b0;
    cyc(2);
    rd("post_reset_gpio_in", A_GPIO_IN, 64'h0F0F);
    rd("post_reset_count", A_COUNT, 64'h0);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_drained: observed %0d left expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_timer_periph.md
Name: gpio_timer_periph

Overview:
Memory-mapped timer/GPIO peripheral on the processor data bus (address, bidirectional data, read, write). It consumes the load/store traffic produced by the datapath. It provides:
- a prescaled 32-bit down-counter with auto-reload and a sticky expiry flag/irq;
- a 16-bit LED output port and a 16-bit synchronized input port, so GPIO timer firmware can poll or pace LED output.

Parameters:
- BASE_ADDR, 64'h0000_0000_0001_0000, byte address of register block; 64-byte aligned.
- GPIO_W, 16, width of gpio_out/gpio_in.
- CNT_W, 32, counter and RELOAD width.
- PRE_W, 16, prescaler width.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- address  in  64  byte address from processor.
- data  inout  64  bus data. Processor drives it on write. Block drives it only while read && hit, else high-Z.
- read  in  1  processor read strobe, level.
- write  in  1  processor write strobe, level.
- gpio_in  in  GPIO_W  external switches/buttons, asynchronous.
- gpio_out  out  GPIO_W  LED register.
- irq  out  1  equals STATUS.expired.

Behaviour:
- hit = (address[63:6] == BASE_ADDR[63:6]). Register index = address[5:3]. address[2:0] ignored.
- Register map (offset: name, access):
  - 0x00 CTRL rw: bit0 EN, bit1 AR (auto-reload).
  - 0x08 PRESCALE rw [PRE_W-1:0].
  - 0x10 RELOAD rw [CNT_W-1:0]. A write also loads COUNT.
  - 0x18 COUNT ro.
  - 0x20 STATUS: bit0 EXP, write-1-to-clear.
  - 0x28 GPIO_OUT rw.
  - 0x30 GPIO_IN ro.
  - 0x38 reserved: reads 0, writes ignored.
- Reads: combinational. data = zero-extended register while read && hit. Zero latency, same cycle.
- Writes: captured on rising clock when write && hit && !read. read && write together: read wins, no write.
- Writes to read-only or reserved offsets have no effect. Unused upper bits read 0.
- Reset values: CTRL=0, PRESCALE=0, RELOAD=0, COUNT=0, STATUS=0, gpio_out=0, prescaler=0, sync flops=0, irq=0, data=Z.
- GPIO_IN: two-flop synchronizer. A gpio_in change is visible on a read two clocks later.
- Prescaler (internal, PRE_W bits):
  - While EN=1: if pre == PRESCALE, then pre<=0 and tick=1 this cycle; else pre<=pre+1.
  - Tick period = PRESCALE+1 clocks; PRESCALE=0 gives a tick every clock.
  - While EN=0: pre<=0, no ticks.
- Counter on tick:
  - COUNT!=0: COUNT<=COUNT-1.
  - COUNT==0: EXP<=1. If AR=1, COUNT<=RELOAD. If AR=0, EN<=0 (one-shot) and COUNT stays 0.
- Simultaneous events:
  - RELOAD write and tick in same cycle: write wins; COUNT<=new RELOAD, and that tick does not decrement.
  - CTRL write and hardware EN clear in same cycle: CTRL write wins.
  - STATUS W1C and expiry in same cycle: set wins, EXP=1.
  - Writing CTRL.EN 0→1 restarts the prescaler from 0.
- Reset mid-count: all state immediately returns to reset values, asynchronously. irq deasserts without waiting for a clock edge.
- No wrap below 0; expiry is the only event at COUNT==0.

Decomposition:
- Shared package gpio_timer_pkg:
  - register offset constants (OFF_CTRL…OFF_GPIO_IN);
  - CTRL bit indices (CTRL_EN, CTRL_AR);
  - STATUS_EXP index;
  - default BASE_ADDR.
- One natural sub-module: timer_prescaler. Inputs: clock, reset, en, restart, prescale. Output: tick. Register file, counter and bus logic stay in the top.

Test Plan:
- Reset/readback: assert reset mid-operation with irq=1 → irq, gpio_out, all registers read 0 immediately, and data is Z when not addressed.
- GPIO: write 0xA5A5 to 0x28 → gpio_out=0xA5A5 next edge, reads 0xA5A5. Drive gpio_in=0x0F0F → a read of 0x30 returns 0x0F0F at the 2nd clock after the change. Reads at non-hit addresses leave data Z.
- One-shot: PRESCALE=0, RELOAD=3, CTRL=EN → COUNT reads 3,2,1,0 on successive ticks. EXP/irq rise on the 4th tick (5th clock after EN). CTRL.EN reads 0, COUNT holds 0.
- Auto-reload with prescale: PRESCALE=4, RELOAD=2, CTRL=EN|AR → expiry every 15 clocks; COUNT reloads 2. A W1C of STATUS=1 clears irq; a W1C coinciding with an expiry keeps irq=1.
- Collisions: RELOAD write coinciding with a tick → COUNT equals the new value, no decrement. read && write together on GPIO_OUT → no update, old value returned.
- Reserved/ro: write to 0x18, 0x30, 0x38 → no state change. 0x38 reads 0. Upper data bits read 0 for all registers.
